// File: rtl/inst_fetch_unit.sv
// Fetch-side initiator: drives imem_addr from the PC and queues {ins,pc} pairs for decode.
// Latency: a fetched word is presented on out_* one cycle after the edge that captured it.
// Backpressure: out_ready=0 holds the head; fetch stalls (pc holds) once the FIFO is full.
module inst_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_ins,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_ins,
  output logic [31:0]              out_pc,
  output logic                     align_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_ins_mem [DEPTH];
  logic [31:0]   r_pc_mem  [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_align_err;

  logic          w_pop;
  logic          w_push;
  logic          w_not_full;

  // Handshake decode: pop only when the head is valid; push needs room or a same-cycle pop.
  always_comb begin
    w_not_full = (r_count < CW'(DEPTH));
    w_pop      = out_valid & out_ready;
    w_push     = fetch_en & ~redirect_valid & (w_not_full | w_pop);
  end

  assign imem_addr = r_pc;
  assign out_valid = (r_count != '0);
  assign out_ins   = r_ins_mem[r_rd_ptr];
  assign out_pc    = r_pc_mem[r_rd_ptr];
  assign align_err = r_align_err;
  assign count     = r_count;

  // PC register: redirect wins over sequential fetch; low address bits are forced to word alignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        r_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_push) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

  // FIFO storage: written at the tail on push; cleared on reset so the idle head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ins_mem[i] <= '0;
        r_pc_mem[i]  <= '0;
      end
    end else if (w_push) begin
      r_ins_mem[r_wr_ptr] <= imem_ins;
      r_pc_mem[r_wr_ptr]  <= r_pc;
    end
  end

  // FIFO pointers and occupancy: a redirect flushes everything, including a same-cycle pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
